// File: rtl/lcd_responder_pkg.sv
// Shared types and constants for the HD44780-style LCD responder.
// Holds bus codes, FSM states, command classes and the DDRAM write-port payload.
package lcd_responder_pkg;

    localparam int unsigned DDRAM_DEPTH = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned DATA_W      = 8;

    localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

    // {RS, RW} bus codes
    localparam logic [1:0] CTRL_CMD_WR  = 2'b00;
    localparam logic [1:0] CTRL_STAT_RD = 2'b01;
    localparam logic [1:0] CTRL_DATA_WR = 2'b10;
    localparam logic [1:0] CTRL_DATA_RD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_CLEAR = 2'd2
    } lcd_state_e;

    typedef enum logic [2:0] {
        CMD_NONE    = 3'd0,
        CMD_CLEAR   = 3'd1,
        CMD_HOME    = 3'd2,
        CMD_ENTRY   = 3'd3,
        CMD_DISPLAY = 3'd4,
        CMD_NOP     = 3'd5,
        CMD_CGRAM   = 3'd6,
        CMD_DDRAM   = 3'd7
    } lcd_cmd_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } ddram_wr_t;

    // Command class is selected by the highest set bit of the command byte.
    function automatic lcd_cmd_e decode_cmd(input logic [DATA_W-1:0] d);
        if (d[7])             return CMD_DDRAM;
        else if (d[6])        return CMD_CGRAM;
        else if (d[5] | d[4]) return CMD_NOP;
        else if (d[3])        return CMD_DISPLAY;
        else if (d[2])        return CMD_ENTRY;
        else if (d[1])        return CMD_HOME;
        else if (d[0])        return CMD_CLEAR;
        else                  return CMD_NONE;
    endfunction

    function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic inc);
        return inc ? a + ADDR_W'(1) : a - ADDR_W'(1);
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 32x8 display data RAM: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset; the controller's clear sequence initialises them.
module lcd_ddram
    import lcd_responder_pkg::*;
(
    input  logic              clk,
    input  ddram_wr_t         wr_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [ADDR_W-1:0] view_addr_i,
    output logic [DATA_W-1:0] view_data_o
);

    logic [DATA_W-1:0] mem_q [DDRAM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_i.we) mem_q[wr_i.addr] <= wr_i.data;
    end

    assign rd_data_o   = mem_q[rd_addr_i];
    assign view_data_o = mem_q[view_addr_i];

endmodule

// File: rtl/lcd_responder.sv
// Receiving end of the 8-bit LCD bus: decodes writes on enable falling edges, tracks busy
// timing, keeps the cursor/flag registers and answers status/data reads.
module lcd_responder
    import lcd_responder_pkg::*;
#(
    parameter int unsigned CMD_CYCLES   = 37,
    parameter int unsigned CLEAR_CYCLES = 1520
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] lcd_data,
    input  logic [1:0]        lcd_ctrl,
    input  logic              lcd_enable,
    output logic [DATA_W-1:0] lcd_rdata,
    output logic              busy,
    output logic              char_valid,
    output logic [DATA_W-1:0] char_out,
    output logic              overrun,
    input  logic [ADDR_W-1:0] view_addr,
    output logic [DATA_W-1:0] view_char,
    output logic              display_on
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > CMD_CYCLES) ? CLEAR_CYCLES : CMD_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

    lcd_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              incr_q;
    logic              en_q;
    logic [DATA_W-1:0] rdata_q;
    logic              char_valid_q;
    logic [DATA_W-1:0] char_out_q;
    logic              overrun_q;
    logic              display_on_q;

    logic              fall_c;
    logic              rise_c;
    logic              idle_c;
    logic              wr_ok_c;
    logic              data_wr_c;
    logic              cmd_wr_c;
    logic              clear_fill_c;
    lcd_cmd_e          cmd_c;
    logic [DATA_W-1:0] rd_char_c;
    ddram_wr_t         ddram_wr_c;

    assign fall_c       = en_q & ~lcd_enable;
    assign rise_c       = ~en_q & lcd_enable;
    assign idle_c       = (state_q == ST_IDLE);
    assign wr_ok_c      = fall_c & ~lcd_ctrl[0] & idle_c;
    assign data_wr_c    = wr_ok_c & (lcd_ctrl == CTRL_DATA_WR);
    assign cmd_wr_c     = wr_ok_c & (lcd_ctrl == CTRL_CMD_WR);
    assign clear_fill_c = (state_q == ST_CLEAR) && (cnt_q < CNT_W'(DDRAM_DEPTH));
    assign cmd_c        = decode_cmd(lcd_data);

    // Blank fill during CLEAR and bus data writes never overlap: data writes need IDLE.
    always_comb begin
        ddram_wr_c = '0;
        if (clear_fill_c) begin
            ddram_wr_c.we   = 1'b1;
            ddram_wr_c.addr = cnt_q[ADDR_W-1:0];
            ddram_wr_c.data = BLANK_CHAR;
        end else if (data_wr_c) begin
            ddram_wr_c.we   = 1'b1;
            ddram_wr_c.addr = addr_q;
            ddram_wr_c.data = lcd_data;
        end
    end

    lcd_ddram u_ddram (
        .clk         (clk),
        .wr_i        (ddram_wr_c),
        .rd_addr_i   (addr_q),
        .rd_data_o   (rd_char_c),
        .view_addr_i (view_addr),
        .view_data_o (view_char)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CLEAR;
            cnt_q        <= CLEAR_LOAD;
            addr_q       <= '0;
            incr_q       <= 1'b1;
            en_q         <= 1'b0;
            rdata_q      <= '0;
            char_valid_q <= 1'b0;
            char_out_q   <= '0;
            overrun_q    <= 1'b0;
            display_on_q <= 1'b0;
        end else begin
            en_q         <= lcd_enable;
            char_valid_q <= 1'b0;

            if (!idle_c) begin
                if (cnt_q == '0) state_q <= ST_IDLE;
                else             cnt_q   <= cnt_q - CNT_W'(1);
            end

            // Writes landing while busy (including the final busy cycle) are dropped.
            if (fall_c && !lcd_ctrl[0] && !idle_c) overrun_q <= 1'b1;

            if (data_wr_c) begin
                char_out_q   <= lcd_data;
                char_valid_q <= 1'b1;
                addr_q       <= step_addr(addr_q, incr_q);
                state_q      <= ST_BUSY;
                cnt_q        <= CMD_LOAD;
            end

            if (cmd_wr_c) begin
                unique case (cmd_c)
                    CMD_DDRAM: begin
                        addr_q  <= {lcd_data[6], lcd_data[3:0]};
                        state_q <= ST_BUSY;
                        cnt_q   <= CMD_LOAD;
                    end
                    CMD_CGRAM, CMD_NOP: begin
                        state_q <= ST_BUSY;
                        cnt_q   <= CMD_LOAD;
                    end
                    CMD_DISPLAY: begin
                        display_on_q <= lcd_data[2];
                        state_q      <= ST_BUSY;
                        cnt_q        <= CMD_LOAD;
                    end
                    CMD_ENTRY: begin
                        incr_q  <= lcd_data[1];
                        state_q <= ST_BUSY;
                        cnt_q   <= CMD_LOAD;
                    end
                    CMD_HOME: begin
                        addr_q  <= '0;
                        state_q <= ST_BUSY;
                        cnt_q   <= CLEAR_LOAD;
                    end
                    CMD_CLEAR: begin
                        addr_q  <= '0;
                        incr_q  <= 1'b1;
                        state_q <= ST_CLEAR;
                        cnt_q   <= CLEAR_LOAD;
                    end
                    default: ;
                endcase
            end

            // Reads are serviced regardless of busy; a data read advances the cursor on its fall.
            if (rise_c && lcd_ctrl[0]) begin
                rdata_q <= lcd_ctrl[1] ? rd_char_c : {~idle_c, 2'b00, addr_q};
            end
            if (fall_c && (lcd_ctrl == CTRL_DATA_RD)) addr_q <= step_addr(addr_q, incr_q);
        end
    end

    assign lcd_rdata  = rdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign char_valid = char_valid_q;
    assign char_out   = char_out_q;
    assign overrun    = overrun_q;
    assign display_on = display_on_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: vector table of bus writes plus hand sequences for
// init timing, busy-time reads, overrun boundaries, reset mid-clear and MMIO-style programming.
module tb_lcd_responder;

    localparam int unsigned CMD_CYC   = 37;
    localparam int unsigned CLEAR_CYC = 1520;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
    localparam logic [1:0]  C_CMD  = 2'b00;
    localparam logic [1:0]  C_STAT = 2'b01;
    localparam logic [1:0]  C_DWR  = 2'b10;
    localparam logic [1:0]  C_DRD  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] lcd_data = 8'h00;
    logic [1:0] lcd_ctrl = 2'b00;
    logic       lcd_enable = 1'b0;
    logic [7:0] lcd_rdata;
    logic       busy;
    logic       char_valid;
    logic [7:0] char_out;
    logic       overrun;
    logic [4:0] view_addr = 5'd0;
    logic [7:0] view_char;
    logic       display_on;

    int tests = 0;
    int fails = 0;
    logic [7:0] mon_q[$];

    lcd_responder #(.CMD_CYCLES(CMD_CYC), .CLEAR_CYCLES(CLEAR_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_data   (lcd_data),
        .lcd_ctrl   (lcd_ctrl),
        .lcd_enable (lcd_enable),
        .lcd_rdata  (lcd_rdata),
        .busy       (busy),
        .char_valid (char_valid),
        .char_out   (char_out),
        .overrun    (overrun),
        .view_addr  (view_addr),
        .view_char  (view_char),
        .display_on (display_on)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (char_valid === 1'b1) mon_q.push_back(char_out);
    end

    typedef struct {
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [4:0] vaddr;
        logic [7:0] view;
        logic [7:0] status;
        logic [7:0] cout;
        logic       disp;
        int         busy_cyc;
    } vec_t;

    vec_t vecs[24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the write has committed.
    task automatic bus_write(input logic [1:0] ctrl, input logic [7:0] data);
        lcd_ctrl   = ctrl;
        lcd_data   = data;
        lcd_enable = 1'b1;
        @(negedge clk);
        lcd_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [1:0] ctrl, output logic [7:0] rd);
        lcd_ctrl   = ctrl;
        lcd_enable = 1'b1;
        @(negedge clk);
        rd         = lcd_rdata;
        lcd_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 4000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 4000) check("busy_timeout", 32'(n), 32'd0);
    endtask

    task automatic view_check(input string name, input logic [4:0] a, input logic [7:0] exp);
        view_addr = a;
        #1;
        check(name, 32'(view_char), 32'(exp));
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [7:0] v);
        @(negedge clk);
        if (a == MMIO_BASE)                lcd_data   = v;
        else if (a == MMIO_BASE + 32'd1)   lcd_ctrl   = v[1:0];
        else if (a == MMIO_BASE + 32'd2)   lcd_enable = v[0];
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] rd;
        logic [7:0] hello[5];

        vecs[0]  = '{C_DWR, 8'h48, 5'd0,  8'h48, 8'h01, 8'h48, 1'b0, CMD_CYC};
        vecs[1]  = '{C_DWR, 8'h69, 5'd1,  8'h69, 8'h02, 8'h69, 1'b0, CMD_CYC};
        vecs[2]  = '{C_CMD, 8'hC0, 5'd16, 8'h20, 8'h10, 8'h69, 1'b0, CMD_CYC};
        vecs[3]  = '{C_DWR, 8'h58, 5'd16, 8'h58, 8'h11, 8'h58, 1'b0, CMD_CYC};
        vecs[4]  = '{C_CMD, 8'hDF, 5'd31, 8'h20, 8'h1F, 8'h58, 1'b0, CMD_CYC};
        vecs[5]  = '{C_DWR, 8'h61, 5'd31, 8'h61, 8'h00, 8'h61, 1'b0, CMD_CYC};
        vecs[6]  = '{C_DWR, 8'h62, 5'd0,  8'h62, 8'h01, 8'h62, 1'b0, CMD_CYC};
        vecs[7]  = '{C_CMD, 8'h9F, 5'd15, 8'h20, 8'h0F, 8'h62, 1'b0, CMD_CYC};
        vecs[8]  = '{C_CMD, 8'h04, 5'd15, 8'h20, 8'h0F, 8'h62, 1'b0, CMD_CYC};
        vecs[9]  = '{C_CMD, 8'h80, 5'd0,  8'h62, 8'h00, 8'h62, 1'b0, CMD_CYC};
        vecs[10] = '{C_DWR, 8'h7A, 5'd0,  8'h7A, 8'h1F, 8'h7A, 1'b0, CMD_CYC};
        vecs[11] = '{C_DWR, 8'h79, 5'd31, 8'h79, 8'h1E, 8'h79, 1'b0, CMD_CYC};
        vecs[12] = '{C_CMD, 8'h06, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b0, CMD_CYC};
        vecs[13] = '{C_CMD, 8'h0C, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, CMD_CYC};
        vecs[14] = '{C_CMD, 8'h08, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b0, CMD_CYC};
        vecs[15] = '{C_CMD, 8'h0F, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, CMD_CYC};
        vecs[16] = '{C_CMD, 8'h30, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, CMD_CYC};
        vecs[17] = '{C_CMD, 8'h10, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, CMD_CYC};
        vecs[18] = '{C_CMD, 8'h40, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, CMD_CYC};
        vecs[19] = '{C_CMD, 8'h00, 5'd1,  8'h69, 8'h1E, 8'h79, 1'b1, 0};
        vecs[20] = '{C_CMD, 8'h02, 5'd0,  8'h7A, 8'h00, 8'h79, 1'b1, CLEAR_CYC};
        vecs[21] = '{C_CMD, 8'h04, 5'd0,  8'h7A, 8'h00, 8'h79, 1'b1, CMD_CYC};
        vecs[22] = '{C_CMD, 8'h01, 5'd31, 8'h20, 8'h00, 8'h79, 1'b1, CLEAR_CYC};
        vecs[23] = '{C_DWR, 8'h71, 5'd0,  8'h71, 8'h01, 8'h71, 1'b1, CMD_CYC};

        // Reset values and init timing
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rdata", 32'(lcd_rdata), 32'd0);
        check("rst_char_valid", 32'(char_valid), 32'd0);
        check("rst_char_out", 32'(char_out), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_display_on", 32'(display_on), 32'd0);
        rst_n = 1'b1;
        wait_idle(n);
        check("init_busy_cycles", 32'(n), 32'(CLEAR_CYC));
        for (int i = 0; i < 32; i++) view_check($sformatf("init_blank[%0d]", i), 5'(i), 8'h20);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 24; i++) begin
            bus_write(vecs[i].ctrl, vecs[i].data);
            check($sformatf("v%0d_char_valid", i), 32'(char_valid), 32'(vecs[i].ctrl == C_DWR));
            wait_idle(n);
            check($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(vecs[i].busy_cyc));
            bus_read(C_STAT, rd);
            check($sformatf("v%0d_status", i), 32'(rd), 32'(vecs[i].status));
            view_check($sformatf("v%0d_view", i), vecs[i].vaddr, vecs[i].view);
            check($sformatf("v%0d_char_out", i), 32'(char_out), 32'(vecs[i].cout));
            check($sformatf("v%0d_display_on", i), 32'(display_on), 32'(vecs[i].disp));
            @(negedge clk);
        end

        // Status read while busy after a decrementing write at address 0
        bus_write(C_CMD, 8'h04); wait_idle(n);
        bus_write(C_CMD, 8'h80); wait_idle(n);
        bus_write(C_DWR, 8'h7A);
        bus_read(C_STAT, rd);
        check("busy_status_read", 32'(rd), 32'h9F);
        wait_idle(n);
        view_check("z_at_0", 5'd0, 8'h7A);
        @(negedge clk);

        // Data read returns DDRAM[addr] and steps the cursor without going busy
        bus_write(C_CMD, 8'h80); wait_idle(n);
        bus_read(C_DRD, rd);
        check("data_read", 32'(rd), 32'h7A);
        check("data_read_not_busy", 32'(busy), 32'd0);
        bus_read(C_STAT, rd);
        check("data_read_addr_step", 32'(rd), 32'h1F);

        // Overrun: write landing on the final busy cycle, then one 5 cycles into busy
        bus_write(C_CMD, 8'h06); wait_idle(n);
        bus_write(C_CMD, 8'h85); wait_idle(n);
        check("overrun_clear", 32'(overrun), 32'd0);
        bus_write(C_DWR, 8'h50);
        repeat (35) @(negedge clk);
        check("last_busy_cycle", 32'(busy), 32'd1);
        bus_write(C_DWR, 8'h51);
        check("drop_last_valid", 32'(char_valid), 32'd0);
        check("drop_last_overrun", 32'(overrun), 32'd1);
        check("drop_last_char_out", 32'(char_out), 32'h50);
        wait_idle(n);
        bus_read(C_STAT, rd);
        check("drop_last_addr", 32'(rd), 32'h06);
        view_check("drop_last_ddram", 5'd6, 8'h20);
        @(negedge clk);
        bus_write(C_DWR, 8'h52);
        repeat (3) @(negedge clk);
        bus_write(C_DWR, 8'h53);
        check("drop_mid_valid", 32'(char_valid), 32'd0);
        wait_idle(n);
        view_check("accept_after_idle", 5'd6, 8'h52);
        view_check("drop_mid_ddram", 5'd7, 8'h20);
        @(negedge clk);
        bus_write(C_DWR, 8'h54);
        check("valid_after_overrun", 32'(char_valid), 32'd1);
        wait_idle(n);
        view_check("write_after_overrun", 5'd7, 8'h54);
        check("overrun_sticky", 32'(overrun), 32'd1);
        @(negedge clk);

        // Reset in the middle of a clear, then reprogram through the MMIO registers
        bus_write(C_CMD, 8'h01);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd1);
        check("midrst_rdata", 32'(lcd_rdata), 32'd0);
        check("midrst_char_out", 32'(char_out), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_display_on", 32'(display_on), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle(n);
        check("reinit_busy_cycles", 32'(n), 32'(CLEAR_CYC));
        view_check("reinit_blank7", 5'd7, 8'h20);
        @(negedge clk);

        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        mon_q.delete();
        for (int i = 0; i < 5; i++) begin
            mmio_write(MMIO_BASE,         hello[i]);
            mmio_write(MMIO_BASE + 32'd1, {6'd0, C_DWR});
            mmio_write(MMIO_BASE + 32'd2, 8'h01);
            mmio_write(MMIO_BASE + 32'd2, 8'h00);
            @(negedge clk);
            wait_idle(n);
            check($sformatf("hello_busy[%0d]", i), 32'(n), 32'(CMD_CYC));
        end
        check("hello_count", 32'(mon_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hello_char_out[%0d]", i),
                  32'((i < mon_q.size()) ? mon_q[i] : 8'h00), 32'(hello[i]));
            view_check($sformatf("hello_view[%0d]", i), 5'(i), hello[i]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
